// File: rtl/jhash_pkg.sv
// Shared definitions for the Jenkins hash key feeder.
// Contents: FSM state enum, word/hash/length width constants and the
// result record (hash value plus error flag) returned to the requester.
package jhash_pkg;

    localparam int JH_WORD_W = 64;
    localparam int JH_HASH_W = 32;
    localparam int JH_LEN_W  = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } jh_state_t;

    typedef struct packed {
        logic [JH_HASH_W-1:0] hash;
        logic                 err;
    } jh_result_t;

endpackage

// File: rtl/jhash_key_feeder_if.sv
// Bundle of every non-clock signal of the key feeder: key request channel,
// word stream toward the hash core, core completion strobe and the result
// channel.
//
// Handshake rule for both key_* and res_* channels: a transfer happens on a
// rising clk edge where valid and ready are both 1. The producer keeps valid
// and its payload stable until that edge; ready may change freely and never
// depends on the same cycle's valid.
//
// Modports:
//   slave  - the feeder itself
//   master - the environment (flow-lookup request path + hash core)
interface jhash_key_feeder_if
    import jhash_pkg::*;
#(
    parameter int MAX_WORDS = 4,
    parameter int CNT_W     = 3,
    parameter int LEN_W     = 12
);
    logic                           key_valid;
    logic                           key_ready;
    logic [JH_WORD_W*MAX_WORDS-1:0] key_data;
    logic [CNT_W-1:0]               key_words;

    logic                           hash_ce;
    logic [JH_WORD_W-1:0]           hash_id;
    logic                           hash_last;
    logic [LEN_W-1:0]               hash_len;
    logic                           hash_done;
    logic [JH_HASH_W-1:0]           hash_dout;

    logic                           res_valid;
    logic                           res_ready;
    logic [JH_HASH_W-1:0]           res_hash;
    logic                           res_err;

    modport slave (
        input  key_valid, key_data, key_words, hash_done, hash_dout, res_ready,
        output key_ready, hash_ce, hash_id, hash_last, hash_len,
               res_valid, res_hash, res_err
    );

    modport master (
        output key_valid, key_data, key_words, hash_done, hash_dout, res_ready,
        input  key_ready, hash_ce, hash_id, hash_last, hash_len,
               res_valid, res_hash, res_err
    );

endinterface

// File: rtl/jhash_word_mux.sv
// Registered word selector. When issue is high, the word of key selected by
// idx is registered onto word together with ce=1 and the supplied last flag;
// otherwise all three outputs register to zero.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   issue      emit a word on the next cycle
//   idx        word index into key
//   last       final-word flag to accompany the word
//   key        packed key, word i at [64*i +: 64]
//   word/ce/word_last  registered outputs to the hash core
module jhash_word_mux
    import jhash_pkg::*;
#(
    parameter int MAX_WORDS = 4,
    parameter int CNT_W     = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           issue,
    input  logic [CNT_W-1:0]               idx,
    input  logic                           last,
    input  logic [JH_WORD_W*MAX_WORDS-1:0] key,
    output logic [JH_WORD_W-1:0]           word,
    output logic                           ce,
    output logic                           word_last
);

    logic [JH_WORD_W-1:0] sel_word;

    // Compare-based select keeps an out-of-range idx from reading past key.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            if (idx == CNT_W'(i)) begin
                sel_word = key[i*JH_WORD_W +: JH_WORD_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !issue) begin
            word      <= '0;
            ce        <= 1'b0;
            word_last <= 1'b0;
        end else begin
            word      <= sel_word;
            ce        <= 1'b1;
            word_last <= last;
        end
    end

endmodule

// File: rtl/jhash_key_feeder.sv
// Front end of the Jenkins hash core. Accepts one key per transaction,
// streams its 64-bit words to the core (ce/last/len sideband), waits for the
// core's done strobe (with timeout) and returns the hash on the result
// channel.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   bus         jhash_key_feeder_if.slave (key, hash core and result signals)
//   fsm_state   current FSM state, for observation
module jhash_key_feeder
    import jhash_pkg::*;
#(
    parameter int MAX_WORDS = 4,
    parameter int CNT_W     = 3,
    parameter int LEN_W     = 12,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    jhash_key_feeder_if.slave    bus,
    output jh_state_t            fsm_state
);

    localparam int              TMO_W    = $clog2(TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WORDS);

    jh_state_t                      state_q, state_d;
    logic [CNT_W-1:0]               idx_q, idx_d;
    logic [TMO_W-1:0]               tmo_q, tmo_d;
    jh_result_t                     res_q, res_d;
    logic [JH_WORD_W*MAX_WORDS-1:0] key_q;
    logic [CNT_W-1:0]               len_q;
    logic [LEN_W-1:0]               hash_len_q;

    logic                           key_ready;
    logic                           accept;
    logic                           legal;
    logic                           issue;
    logic                           issue_last;
    logic [CNT_W-1:0]               issue_idx;
    logic [JH_WORD_W*MAX_WORDS-1:0] key_src;
    logic [CNT_W-1:0]               len_src;
    logic [CNT_W-1:0]               nxt_idx;
    logic [CNT_W-1:0]               last_idx;

    assign key_ready = (state_q == IDLE) && !rst;
    assign legal     = (bus.key_words != '0) && (bus.key_words <= MAX_CNT);
    assign nxt_idx   = idx_q + CNT_W'(1);
    assign last_idx  = len_q - CNT_W'(1);

    // Word 0 is issued on the accept edge straight from key_data, so while in
    // SEND idx_q names the word currently on hash_id and the mux is fed the
    // following one.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        res_d      = res_q;
        accept     = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_idx  = '0;
        key_src    = key_q;
        len_src    = len_q;

        case (state_q)
            IDLE: begin
                if (bus.key_valid && key_ready) begin
                    accept  = 1'b1;
                    key_src = bus.key_data;
                    len_src = bus.key_words;
                    idx_d   = '0;
                    tmo_d   = '0;
                    if (legal) begin
                        issue      = 1'b1;
                        issue_last = (bus.key_words == CNT_W'(1));
                        state_d    = SEND;
                    end else begin
                        res_d   = '{hash: '0, err: 1'b1};
                        state_d = RESP;
                    end
                end
            end
            SEND: begin
                if (idx_q == last_idx) begin
                    idx_d   = '0;
                    tmo_d   = '0;
                    state_d = WAIT;
                end else begin
                    idx_d      = nxt_idx;
                    issue      = 1'b1;
                    issue_idx  = nxt_idx;
                    issue_last = (nxt_idx == last_idx);
                end
            end
            WAIT: begin
                // done wins over the terminal count when both land together
                if (bus.hash_done) begin
                    res_d   = '{hash: bus.hash_dout, err: 1'b0};
                    state_d = RESP;
                end else if (tmo_q == TMO_LAST) begin
                    res_d   = '{hash: '0, err: 1'b1};
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            RESP: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            tmo_q      <= '0;
            res_q      <= '0;
            key_q      <= '0;
            len_q      <= '0;
            hash_len_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            res_q   <= res_d;
            if (accept) begin
                key_q <= bus.key_data;
                len_q <= bus.key_words;
            end
            hash_len_q <= issue ? {{(LEN_W-CNT_W){1'b0}}, len_src} : '0;
        end
    end

    jhash_word_mux #(
        .MAX_WORDS (MAX_WORDS),
        .CNT_W     (CNT_W)
    ) u_word_mux (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .idx       (issue_idx),
        .last      (issue_last),
        .key       (key_src),
        .word      (bus.hash_id),
        .ce        (bus.hash_ce),
        .word_last (bus.hash_last)
    );

    assign bus.key_ready = key_ready;
    assign bus.hash_len  = hash_len_q;
    assign bus.res_valid = (state_q == RESP);
    assign bus.res_hash  = res_q.hash;
    assign bus.res_err   = res_q.err;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_jhash_key_feeder.sv
// Self-checking bench for jhash_key_feeder: directed cases for single/four
// word keys, illegal lengths, timeout, backpressure and mid-SEND reset,
// followed by randomized transactions checked against a transaction-level
// model of the expected word stream, result and result timing.
module tb_jhash_key_feeder;
    import jhash_pkg::*;

    localparam int MAX_WORDS = 4;
    localparam int CNT_W     = 3;
    localparam int LEN_W     = 12;
    localparam int TIMEOUT   = 16;
    localparam int KEY_W     = JH_WORD_W * MAX_WORDS;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    jh_state_t fsm_state;

    jhash_key_feeder_if #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

    jhash_key_feeder #(
        .MAX_WORDS (MAX_WORDS),
        .CNT_W     (CNT_W),
        .LEN_W     (LEN_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Hash core model: one done pulse the cycle after a last word.
    logic        core_en    = 1'b0;
    logic        core_arm   = 1'b0;
    logic        stray_done = 1'b0;
    logic [31:0] core_hash  = '0;

    always @(posedge clk) begin
        #2;
        bus.hash_done = core_arm | stray_done;
        bus.hash_dout = core_arm ? core_hash : $urandom;
        core_arm      = core_en & bus.hash_last;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [KEY_W-1:0] rand_key();
        logic [KEY_W-1:0] r;
        for (int i = 0; i < KEY_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One full transaction: present key, watch the word stream and the
    // result, optionally hold off res_ready, then complete the handshake.
    task automatic run_txn(input logic [KEY_W-1:0] data, input int n, input bit core_on,
                           input logic [31:0] hv, input int hold, input bit stray);
        logic [63:0] exp_q[$];
        int          t0, k, rv_edge, exp_lat, w;
        bit          legal, seen;
        logic [31:0] exp_hash;
        logic        exp_err;

        core_en       = core_on;
        core_hash     = hv;
        bus.res_ready = (hold == 0);

        w = 0;
        while (!bus.key_ready && w < 50) begin
            tick();
            w++;
        end
        chk("key_ready_before_accept", 64'(bus.key_ready), 64'd1);

        bus.key_valid = 1'b1;
        bus.key_data  = data;
        bus.key_words = CNT_W'(n);
        tick();
        t0            = cyc;
        bus.key_valid = 1'b0;
        bus.key_data  = rand_key();
        bus.key_words = CNT_W'($urandom);

        // Reference: legal keys stream words 0..n-1; result from core or timeout.
        legal = (n >= 1) && (n <= MAX_WORDS);
        if (legal) for (int i = 0; i < n; i++) exp_q.push_back(data[i*64 +: 64]);
        if (!legal) begin
            exp_hash = '0; exp_err = 1'b1; exp_lat = 0;
        end else if (core_on) begin
            exp_hash = hv; exp_err = 1'b0; exp_lat = n + 1;
        end else begin
            exp_hash = '0; exp_err = 1'b1; exp_lat = n + TIMEOUT;
        end

        k = 0; seen = 0; rv_edge = 0;
        for (int s = 0; s < 80; s++) begin
            chk("key_ready_busy", 64'(bus.key_ready), 64'd0);
            if (bus.hash_ce) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word_ce", 64'(bus.hash_ce), 64'd0);
                end else begin
                    chk("hash_id", bus.hash_id, exp_q.pop_front());
                    chk("hash_last", 64'(bus.hash_last), 64'(k == n - 1));
                    chk("hash_len", 64'(bus.hash_len), 64'(n));
                    chk("word_cycle", 64'(cyc - t0), 64'(k));
                    k++;
                end
            end
            if (bus.res_valid) begin
                seen    = 1;
                rv_edge = cyc;
                break;
            end
            tick();
        end
        chk("res_valid_seen", 64'(seen), 64'd1);
        chk("word_count", 64'(k), legal ? 64'(n) : 64'd0);
        if (seen) begin
            chk("res_latency", 64'(rv_edge - t0), 64'(exp_lat));
            chk("res_hash", 64'(bus.res_hash), 64'(exp_hash));
            chk("res_err", 64'(bus.res_err), 64'(exp_err));
        end

        for (int i = 0; i < hold; i++) begin
            bus.key_valid = 1'b1;
            bus.key_data  = rand_key();
            bus.key_words = CNT_W'(1);
            if (stray && i == 1) stray_done = 1'b1;
            tick();
            stray_done = 1'b0;
            chk("hold_res_valid", 64'(bus.res_valid), 64'd1);
            chk("hold_res_hash", 64'(bus.res_hash), 64'(exp_hash));
            chk("hold_res_err", 64'(bus.res_err), 64'(exp_err));
            chk("hold_key_ready", 64'(bus.key_ready), 64'd0);
            chk("hold_hash_ce", 64'(bus.hash_ce), 64'd0);
        end
        bus.key_valid = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        chk("post_hs_res_valid", 64'(bus.res_valid), 64'd0);
        chk("post_hs_key_ready", 64'(bus.key_ready), 64'd1);
        chk("post_hs_hash_ce", 64'(bus.hash_ce), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [KEY_W-1:0] kd;
        int               n, bad, t0;

        bus.key_valid = 1'b0;
        bus.key_data  = '0;
        bus.key_words = '0;
        bus.res_ready = 1'b0;

        // Reset values
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_hash_ce", 64'(bus.hash_ce), 64'd0);
        chk("rst_hash_last", 64'(bus.hash_last), 64'd0);
        chk("rst_hash_id", bus.hash_id, 64'd0);
        chk("rst_hash_len", 64'(bus.hash_len), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_hash", 64'(bus.res_hash), 64'd0);
        chk("rst_res_err", 64'(bus.res_err), 64'd0);
        chk("rst_key_ready", 64'(bus.key_ready), 64'd0);
        chk("rst_state", 64'(fsm_state), 64'(IDLE));
        rst = 1'b0;
        tick();
        chk("after_rst_key_ready", 64'(bus.key_ready), 64'd1);
        chk("after_rst_state", 64'(fsm_state), 64'(IDLE));

        // Single word
        kd = rand_key();
        kd[63:0] = 64'h0123_4567_89AB_CDEF;
        run_txn(kd, 1, 1'b1, 32'hDEADBEEF, 0, 1'b0);

        // Four words 1,2,3,4
        kd = {64'd4, 64'd3, 64'd2, 64'd1};
        run_txn(kd, 4, 1'b1, 32'h1234_5678, 0, 1'b0);

        // Illegal lengths
        run_txn(rand_key(), 0, 1'b1, 32'hCAFE_0000, 0, 1'b0);
        run_txn(rand_key(), 5, 1'b1, 32'hCAFE_0001, 0, 1'b0);

        // Timeout, with a stray late done while the result is held
        run_txn(rand_key(), 2, 1'b0, 32'h0BAD_F00D, 3, 1'b1);

        // Backpressure then a second key
        run_txn(rand_key(), 3, 1'b1, $urandom, 10, 1'b0);
        run_txn(rand_key(), 2, 1'b1, $urandom, 0, 1'b0);

        // Randomized transactions
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) != 0) n = $urandom_range(1, MAX_WORDS);
            else if ($urandom_range(0, 1) == 0) n = 0;
            else n = $urandom_range(MAX_WORDS + 1, 7);
            run_txn(rand_key(), n, ($urandom_range(0, 4) != 0), $urandom,
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset during word 2 of a 4-word key
        core_en       = 1'b1;
        bus.res_ready = 1'b1;
        kd            = rand_key();
        bus.key_valid = 1'b1;
        bus.key_data  = kd;
        bus.key_words = CNT_W'(4);
        tick();
        t0            = cyc;
        bus.key_valid = 1'b0;
        tick();
        chk("midrst_word1", bus.hash_id, kd[127:64]);
        chk("midrst_word1_cycle", 64'(cyc - t0), 64'd1);
        rst = 1'b1;
        tick();
        chk("midrst_hash_ce", 64'(bus.hash_ce), 64'd0);
        chk("midrst_hash_id", bus.hash_id, 64'd0);
        chk("midrst_hash_last", 64'(bus.hash_last), 64'd0);
        chk("midrst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("midrst_key_ready", 64'(bus.key_ready), 64'd0);
        rst = 1'b0;
        tick();
        chk("midrst_key_ready_after", 64'(bus.key_ready), 64'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.res_valid || bus.hash_ce || !bus.key_ready) bad++;
            tick();
        end
        chk("midrst_quiet_cycles_bad", 64'(bad), 64'd0);

        // Recovery after reset
        run_txn(rand_key(), 4, 1'b1, $urandom, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
